// File: rtl/mmm_pkg.sv
// mmm_pkg: types and constants shared by the matrix-multiply BRAM tile
// reader and tile writer.
//   state_t     : tile walker FSM states
//   FIFO_DEPTH  : output skid FIFO depth of the reader
//   tile_desc_t : tile descriptor {base, rows, cols, stride}
package mmm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned OCC_W      = $clog2(FIFO_DEPTH + 1);

  localparam int unsigned DESC_ADDR_W = 9;
  localparam int unsigned DESC_DIM_W  = 8;

  typedef struct packed {
    logic [DESC_ADDR_W-1:0] base;
    logic [DESC_DIM_W-1:0]  rows;
    logic [DESC_DIM_W-1:0]  cols;
    logic [DESC_ADDR_W-1:0] stride;
  } tile_desc_t;

endpackage

// File: rtl/tile_reader_fifo.sv
// tile_reader_fifo: 2-entry registered FIFO between the BRAM read port and
// the tile reader output stream. Push and pop may occur in the same cycle,
// including when full.
//   clk, rst     : clock, asynchronous active-high reset
//   i_push       : write i_push_data this cycle
//   i_push_data  : entry {last, data}
//   i_pop        : remove the head entry this cycle
//   o_occ        : number of stored entries (0..2)
//   o_head       : oldest entry, stable until popped
module tile_reader_fifo
  import mmm_pkg::*;
#(
  parameter int unsigned WIDTH = 65
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [OCC_W-1:0] o_occ,
  output logic [WIDTH-1:0] o_head
);

  logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic             r_rd_ptr;
  logic             r_wr_ptr;
  logic [OCC_W-1:0] r_occ;
  logic             w_do_pop;
  logic             w_do_push;

  assign w_do_pop  = i_pop && (r_occ != '0);
  // A pop frees its slot in the same cycle, so a full FIFO still accepts.
  assign w_do_push = i_push && ((r_occ != OCC_W'(FIFO_DEPTH)) || w_do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_occ    <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_do_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_occ <= r_occ + OCC_W'(1);
        2'b01:   r_occ <= r_occ - OCC_W'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign o_occ  = r_occ;
  assign o_head = r_mem[r_rd_ptr];

endmodule

// File: rtl/mcd_bram_tile_reader.sv
// mcd_bram_tile_reader: walks a tile row-major over one read port of the MCD
// dual-port BRAM and streams the words out on a valid/ready interface.
//   clk, rst                        : clock, asynchronous active-high reset
//   cmd_valid/cmd_ready             : descriptor handshake (ready only in IDLE)
//   cmd_base/rows/cols/stride       : tile descriptor
//   bram_en/addr/write_en/write_data: RAM port (read-only use)
//   bram_read_data                  : RAM data, one cycle after bram_en
//   out_valid/ready/data/last       : tile element stream, last on final word
//   done                            : one-cycle pulse after the tile drains
module mcd_bram_tile_reader
  import mmm_pkg::*;
#(
  parameter int unsigned addr_width = 9,
  parameter int unsigned data_width = 64,
  parameter int unsigned dim_width  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [addr_width-1:0] cmd_base,
  input  logic [dim_width-1:0]  cmd_rows,
  input  logic [dim_width-1:0]  cmd_cols,
  input  logic [addr_width-1:0] cmd_stride,
  output logic                  bram_en,
  output logic [addr_width-1:0] bram_addr,
  output logic                  bram_write_en,
  output logic [data_width-1:0] bram_write_data,
  input  logic [data_width-1:0] bram_read_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [data_width-1:0] out_data,
  output logic                  out_last,
  output logic                  done
);

  state_t                r_state;
  state_t                w_next;
  logic                  r_cmd_ready;
  logic                  r_inflight;
  logic                  r_last_inflight;
  logic                  r_drain_seen;
  logic [addr_width-1:0] r_row_base;
  logic [addr_width-1:0] r_stride;
  logic [dim_width-1:0]  r_rows;
  logic [dim_width-1:0]  r_cols;
  logic [dim_width-1:0]  r_row;
  logic [dim_width-1:0]  r_col;

  logic                  w_accept;
  logic                  w_issue;
  logic                  w_done;
  logic                  w_is_last;
  logic                  w_col_wrap;
  logic                  w_out_valid;
  logic                  w_pop;
  logic                  w_room;
  logic [OCC_W-1:0]      w_occ;
  logic [2:0]            w_pending;
  logic [data_width:0]   w_head;

  tile_reader_fifo #(
    .WIDTH(data_width + 1)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (r_inflight),
    .i_push_data ({r_last_inflight, bram_read_data}),
    .i_pop       (w_pop),
    .o_occ       (w_occ),
    .o_head      (w_head)
  );

  assign w_out_valid = (w_occ != '0);
  assign w_pop       = w_out_valid && out_ready;
  assign w_pending   = 3'(w_occ) + 3'(r_inflight);
  // Issue only if the word will have a FIFO slot, counting this cycle's pop.
  assign w_room      = (w_pending < (3'd2 + 3'(w_pop)));
  assign w_col_wrap  = (r_col == (r_cols - dim_width'(1)));
  assign w_is_last   = w_col_wrap && (r_row == (r_rows - dim_width'(1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_issue  = 1'b0;
    w_done   = 1'b0;
    case (r_state)
      IDLE: begin
        w_accept = r_cmd_ready && cmd_valid;
        if (w_accept) begin
          w_next = ((cmd_rows == '0) || (cmd_cols == '0)) ? DRAIN : RUN;
        end
      end
      RUN: begin
        w_issue = w_room;
        if (w_issue && w_is_last) begin
          w_next = DRAIN;
        end
      end
      DRAIN: begin
        // Requiring a prior DRAIN cycle gives an empty tile the same
        // accept-to-done spacing as a read's capture slot.
        if (!r_inflight && (w_occ == '0) && r_drain_seen) begin
          w_done = 1'b1;
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cmd_ready     <= 1'b0;
      r_inflight      <= 1'b0;
      r_last_inflight <= 1'b0;
      r_drain_seen    <= 1'b0;
      r_row_base      <= '0;
      r_stride        <= '0;
      r_rows          <= '0;
      r_cols          <= '0;
      r_row           <= '0;
      r_col           <= '0;
    end else begin
      r_cmd_ready     <= (w_next == IDLE);
      r_inflight      <= w_issue;
      r_last_inflight <= w_issue && w_is_last;
      r_drain_seen    <= (r_state == DRAIN);
      if (w_accept) begin
        r_rows     <= cmd_rows;
        r_cols     <= cmd_cols;
        r_stride   <= cmd_stride;
        r_row_base <= cmd_base;
        r_row      <= '0;
        r_col      <= '0;
      end else if (w_issue) begin
        if (w_col_wrap) begin
          r_col      <= '0;
          r_row      <= r_row + dim_width'(1);
          r_row_base <= r_row_base + r_stride;
        end else begin
          r_col <= r_col + dim_width'(1);
        end
      end
    end
  end

  assign cmd_ready       = r_cmd_ready;
  assign bram_en         = w_issue;
  assign bram_addr       = w_issue ? (r_row_base + addr_width'(r_col)) : '0;
  assign bram_write_en   = 1'b0;
  assign bram_write_data = '0;
  assign out_valid       = w_out_valid;
  assign out_data        = w_head[data_width-1:0];
  assign out_last        = w_head[data_width] && w_out_valid;
  assign done            = w_done;

endmodule

// File: tb/tb_mcd_bram_tile_reader.sv
// Self-checking bench for mcd_bram_tile_reader.
module tb_mcd_bram_tile_reader;

  localparam int AW   = 9;
  localparam int DW   = 64;
  localparam int DIMW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_base;
  logic [DIMW-1:0] cmd_rows;
  logic [DIMW-1:0] cmd_cols;
  logic [AW-1:0] cmd_stride;
  logic          bram_en;
  logic [AW-1:0] bram_addr;
  logic          bram_write_en;
  logic [DW-1:0] bram_write_data;
  logic [DW-1:0] bram_read_data = '0;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          done;

  mcd_bram_tile_reader #(
    .addr_width(AW),
    .data_width(DW),
    .dim_width (DIMW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_base       (cmd_base),
    .cmd_rows       (cmd_rows),
    .cmd_cols       (cmd_cols),
    .cmd_stride     (cmd_stride),
    .bram_en        (bram_en),
    .bram_addr      (bram_addr),
    .bram_write_en  (bram_write_en),
    .bram_write_data(bram_write_data),
    .bram_read_data (bram_read_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_last       (out_last),
    .done           (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] ram_word(input logic [AW-1:0] a);
    return {16'hC0DE, 7'd0, a, 23'd0, a ^ 9'h155};
  endfunction

  // Registered-read RAM model.
  always @(posedge clk) if (bram_en) bram_read_data <= ram_word(bram_addr);

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Scoreboard: expected addresses and {last,data} words, pushed when a
  // descriptor is driven.
  logic [AW-1:0] exp_addr_q[$];
  logic [64:0]   exp_data_q[$];

  task automatic push_expect(input logic [AW-1:0] base, input int rows, input int cols,
                             input logic [AW-1:0] stride);
    logic [AW-1:0] a;
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < cols; c++) begin
        a = AW'(int'(base) + r * int'(stride) + c);
        exp_addr_q.push_back(a);
        exp_data_q.push_back({(r == rows - 1) && (c == cols - 1), ram_word(a)});
      end
    end
  endtask

  // Output-ready pattern generator.
  int         rdy_mode = 0;
  logic [3:0] rdy_pat  = 4'b1001;
  int         rdy_ph   = 0;
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: begin
          out_ready = rdy_pat[3 - rdy_ph];
          rdy_ph    = (rdy_ph + 1) % 4;
        end
        2: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: address order, issue gating, output order, stall stability.
  int          outstanding = 0;
  bit          prev_stall  = 1'b0;
  logic [64:0] prev_word   = '0;
  int          done_count  = 0;
  always @(negedge clk) begin
    if (rst) begin
      outstanding = 0;
      prev_stall  = 1'b0;
    end else begin
      if (bram_en) begin
        if (exp_addr_q.size() == 0) chk("bram_en_unexpected", bram_en, 1'b0);
        else chk("bram_addr", bram_addr, exp_addr_q.pop_front());
        chk("issue_room", (outstanding < 2 + int'(out_valid & out_ready)), 1'b1);
        chk("bram_write_en", bram_write_en, 1'b0);
        chk("bram_write_data", bram_write_data, '0);
      end
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1'b1);
        chk("stall_word", {out_last, out_data}, prev_word);
      end
      if (out_valid && out_ready) begin
        if (exp_data_q.size() == 0) chk("out_unexpected", out_valid, 1'b0);
        else chk("out_word", {out_last, out_data}, exp_data_q.pop_front());
      end
      if (done) done_count++;
      outstanding = outstanding + int'(bram_en) - int'(out_valid & out_ready);
      prev_stall  = out_valid & ~out_ready;
      prev_word   = {out_last, out_data};
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [AW-1:0]   base;
    logic [DIMW-1:0] rows;
    logic [DIMW-1:0] cols;
    logic [AW-1:0]   stride;
    int              mode;      // out_ready pattern
    int              done_lat;  // expected done cycle minus accept cycle, -1 = unchecked
  } tile_vec_t;

  tile_vec_t vecs[9];

  task automatic wait_cmd_ready(output bit ok);
    for (int i = 0; i < 50 && !cmd_ready; i++) begin
      @(posedge clk);
      #1;
    end
    ok = cmd_ready;
    if (!ok) chk("cmd_ready_wait", cmd_ready, 1'b1);
  endtask

  task automatic wait_done(output int d);
    d = -1;
    for (int i = 0; i < 400; i++) begin
      if (done) begin
        d = cyc;
        break;
      end
      @(negedge clk);
    end
    if (d < 0) chk("done_timeout", done, 1'b1);
  endtask

  task automatic drive_cmd(input logic [AW-1:0] base, input logic [DIMW-1:0] rows,
                           input logic [DIMW-1:0] cols, input logic [AW-1:0] stride);
    cmd_base   = base;
    cmd_rows   = rows;
    cmd_cols   = cols;
    cmd_stride = stride;
    cmd_valid  = 1'b1;
  endtask

  task automatic run_tile(input tile_vec_t v);
    bit ok;
    int t0;
    int d;
    int n;
    n = int'(v.rows) * int'(v.cols);
    @(posedge clk);
    #1;
    wait_cmd_ready(ok);
    if (!ok) return;
    push_expect(v.base, int'(v.rows), int'(v.cols), v.stride);
    rdy_mode = v.mode;
    drive_cmd(v.base, v.rows, v.cols, v.stride);
    t0 = cyc;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("cmd_ready_busy", cmd_ready, 1'b0);
    if (n > 0) chk("first_issue", bram_en, 1'b1);
    wait_done(d);
    if (d >= 0) begin
      chk("cmd_ready_at_done", cmd_ready, 1'b0);
      if (v.done_lat >= 0) chk("done_cycle", d - t0, v.done_lat);
      @(negedge clk);
      chk("done_one_pulse", done, 1'b0);
      chk("cmd_ready_after_done", cmd_ready, 1'b1);
    end
    chk("addr_queue_empty", exp_addr_q.size(), 0);
    chk("data_queue_empty", exp_data_q.size(), 0);
    rdy_mode = 0;
  endtask

  task automatic seq_reset_midtile();
    bit ok;
    int dc0;
    tile_vec_t v;
    @(posedge clk);
    #1;
    wait_cmd_ready(ok);
    if (!ok) return;
    push_expect(9'h010, 2, 3, 9'h020);
    rdy_mode = 3;
    drive_cmd(9'h010, 8'd2, 8'd3, 9'h020);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("stalled_out_valid", out_valid, 1'b1);
    chk("stalled_no_issue", bram_en, 1'b0);
    chk("stalled_first_word", {out_last, out_data}, {1'b0, ram_word(9'h010)});
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_bram_en", bram_en, 1'b0);
    chk("rst_bram_addr", bram_addr, '0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, '0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_done", done, 1'b0);
    exp_addr_q.delete();
    exp_data_q.delete();
    dc0 = done_count;
    repeat (2) @(posedge clk);
    #1;
    rst      = 1'b0;
    rdy_mode = 0;
    repeat (4) @(negedge clk);
    chk("no_done_after_reset", done_count, dc0);
    v = '{9'h005, 8'd1, 8'd1, 9'h000, 0, 4};
    run_tile(v);
  endtask

  task automatic seq_back_to_back();
    bit ok;
    int t1;
    int t2;
    int d1;
    int d2;
    @(posedge clk);
    #1;
    wait_cmd_ready(ok);
    if (!ok) return;
    push_expect(9'h010, 2, 3, 9'h020);
    push_expect(9'h080, 1, 2, 9'h000);
    drive_cmd(9'h010, 8'd2, 8'd3, 9'h020);
    t1 = cyc;
    @(posedge clk);
    #1;
    drive_cmd(9'h080, 8'd1, 8'd2, 9'h000);
    @(negedge clk);
    chk("b2b_held_off", cmd_ready, 1'b0);
    wait_done(d1);
    if (d1 < 0) begin
      cmd_valid = 1'b0;
      return;
    end
    chk("b2b_done1_cycle", d1 - t1, 9);
    chk("b2b_ready_at_done", cmd_ready, 1'b0);
    @(negedge clk);
    chk("b2b_ready_after_done", cmd_ready, 1'b1);
    t2 = cyc;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("b2b_tile2_first_issue", bram_en, 1'b1);
    wait_done(d2);
    if (d2 >= 0) chk("b2b_done2_cycle", d2 - t2, 5);
    chk("b2b_addr_queue_empty", exp_addr_q.size(), 0);
    chk("b2b_data_queue_empty", exp_data_q.size(), 0);
  endtask

  initial begin
    vecs[0] = '{9'h010, 8'd2, 8'd3, 9'h020, 0, 9};
    vecs[1] = '{9'h010, 8'd2, 8'd3, 9'h020, 1, -1};
    vecs[2] = '{9'h1FE, 8'd1, 8'd4, 9'h000, 0, 7};
    vecs[3] = '{9'h040, 8'd0, 8'd5, 9'h010, 0, 2};
    vecs[4] = '{9'h050, 8'd3, 8'd0, 9'h010, 0, 2};
    vecs[5] = '{9'h0AA, 8'd1, 8'd1, 9'h000, 0, 4};
    vecs[6] = '{9'h100, 8'd3, 8'd3, 9'h1F0, 2, -1};
    vecs[7] = '{9'h1F0, 8'd4, 8'd5, 9'h007, 2, -1};
    vecs[8] = '{9'h020, 8'd3, 8'd4, 9'h010, 0, 15};

    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_base   = '0;
    cmd_rows   = '0;
    cmd_cols   = '0;
    cmd_stride = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_cmd_ready", cmd_ready, 1'b0);
    chk("reset_bram_en", bram_en, 1'b0);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_out_last", out_last, 1'b0);
    chk("reset_done", done, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("cmd_ready_after_reset", cmd_ready, 1'b1);

    for (int i = 0; i < 9; i++) run_tile(vecs[i]);
    seq_reset_midtile();
    seq_back_to_back();

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
